ysyx_22040759_wb_fifo: RTL

//  Parametrised write-back stage: accepts retiring instructions from MEM, selects the RF write data
//  at enqueue, and buffers results in a DEPTH-entry in-order queue. Each head entry drains to the

---
 rtl/ysyx_22040759_wb_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040759_wb_fifo.sv
// Write-back stage: selects RF write data at enqueue, queues results in order and drains the head
// to the register file under valid/ready. Pending entries can be searched for operand bypass.

module ysyx_22040759_wb_fifo_slot #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ILEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_reg_wen,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RA_W-1:0] byp_raddr,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            reg_wen,
    output logic [RA_W-1:0] rd,
    output logic [XLEN-1:0] wdata,
    output logic            match
);
    // Storage is never reset; the queue gates every use by occupancy.
    always_ff @(posedge clk) begin
        if (we) begin
            inst    <= in_inst;
            pc      <= in_pc;
            reg_wen <= in_reg_wen;
            rd      <= in_rd;
            wdata   <= in_wdata;
        end
    end

    assign match = reg_wen && (rd == byp_raddr);
endmodule

module ysyx_22040759_wb_fifo #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ms_valid,
    output logic            ws_allowin,
    input  logic [ILEN-1:0] ms_inst,
    input  logic [XLEN-1:0] ms_pc,
    input  logic            ms_reg_wen,
    input  logic [RA_W-1:0] ms_rd,
    input  logic [1:0]      ms_wreg_sel,
    input  logic [XLEN-1:0] ms_alu_res,
    input  logic [XLEN-1:0] ms_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_rf_wen,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic [XLEN-1:0] wb_pc,
    output logic [ILEN-1:0] wb_inst,
    input  logic [RA_W-1:0] byp_raddr,
    output logic            byp_hit,
    output logic [XLEN-1:0] byp_data,
    output logic [XLEN-1:0] retire_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [XLEN-1:0] push_wdata;

    logic [DEPTH-1:0][ILEN-1:0] slot_inst;
    logic [DEPTH-1:0][XLEN-1:0] slot_pc;
    logic [DEPTH-1:0][XLEN-1:0] slot_wdata;
    logic [DEPTH-1:0][RA_W-1:0] slot_rd;
    logic [DEPTH-1:0]           slot_wen;
    logic [DEPTH-1:0]           slot_match;
    logic [DEPTH-1:0]           slot_we;

    // allowin depends only on registered occupancy, so a full queue refuses even on a pop cycle.
    assign ws_allowin = (count < CW'(DEPTH));
    assign wb_valid   = (count != '0);
    assign push       = ms_valid && ws_allowin;
    assign pop        = wb_valid && wb_ready;

    always_comb begin
        push_wdata = '0;
        case (ms_wreg_sel)
            2'd0:    push_wdata = ms_pc + XLEN'(4);
            2'd1:    push_wdata = ms_alu_res;
            2'd2:    push_wdata = ms_rdata;
            default: push_wdata = '0;
        endcase
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign slot_we[g] = push && (wr_ptr == PW'(g));

        ysyx_22040759_wb_fifo_slot #(
            .XLEN(XLEN), .ILEN(ILEN), .RA_W(RA_W)
        ) u_slot (
            .clk        (clk),
            .we         (slot_we[g]),
            .in_inst    (ms_inst),
            .in_pc      (ms_pc),
            .in_reg_wen (ms_reg_wen),
            .in_rd      (ms_rd),
            .in_wdata   (push_wdata),
            .byp_raddr  (byp_raddr),
            .inst       (slot_inst[g]),
            .pc         (slot_pc[g]),
            .reg_wen    (slot_wen[g]),
            .rd         (slot_rd[g]),
            .wdata      (slot_wdata[g]),
            .match      (slot_match[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                retire_cnt <= retire_cnt + XLEN'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign wb_rd     = wb_valid ? slot_rd[rd_ptr]    : '0;
    assign wb_wdata  = wb_valid ? slot_wdata[rd_ptr] : '0;
    assign wb_pc     = wb_valid ? slot_pc[rd_ptr]    : '0;
    assign wb_inst   = wb_valid ? slot_inst[rd_ptr]  : '0;
    assign wb_rf_wen = wb_valid && slot_wen[rd_ptr] && (slot_rd[rd_ptr] != '0);

    // Walk oldest to youngest so the last hit (youngest writer) wins.
    logic [PW-1:0] byp_idx;
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && slot_match[byp_idx] && (byp_raddr != '0)) begin
                byp_hit  = 1'b1;
                byp_data = slot_wdata[byp_idx];
            end
        end
    end
endmodule
